// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for an external FIFO storage array.
// It turns valid/ready push and pop handshakes into array enables and indices.
// It also tracks occupancy and decodes the full, empty and threshold flags.
// Optional feature macro: FIFO_CTRL_WATERMARK_EN adds the high_water and
// overflow_err outputs.
module fifo_ctrl #(
  parameter int OSTD_NUM        = 8,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1,
  parameter int CNT_SIZE        = $clog2(OSTD_NUM + 1)
) (
  input  logic                clk_in,
  input  logic                areset_b,
  input  logic                push_valid,
  output logic                push_ready,
  output logic                pop_valid,
  input  logic                pop_ready,
  input  logic                flush,
  output logic                fifo_wenable,
  output logic                fifo_renable,
  output logic [PTR_SIZE-1:0] write_ptr,
  output logic [PTR_SIZE-1:0] read_ptr,
  output logic [CNT_SIZE-1:0] occupancy,
  output logic                full,
  output logic                empty,
  output logic                below_thresh
`ifdef FIFO_CTRL_WATERMARK_EN
  ,
  output logic [CNT_SIZE-1:0] high_water,
  output logic                overflow_err
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_t;

  localparam logic [CNT_SIZE-1:0] OCC_MAX    = CNT_SIZE'(OSTD_NUM);
  localparam logic [CNT_SIZE-1:0] OCC_LAST   = CNT_SIZE'(OSTD_NUM - 1);
  localparam logic [CNT_SIZE-1:0] OCC_ONE    = CNT_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] OCC_THRESH = CNT_SIZE'(THRESHOLD_VALUE);
  localparam logic [PTR_SIZE-1:0] PTR_LAST   = PTR_SIZE'(OSTD_NUM - 1);

  state_t              state;
  state_t              state_next;
  logic                push_fire;
  logic                pop_fire;
  logic [CNT_SIZE-1:0] occ_next;

  // The depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_SIZE'(1);
  endfunction

  // The flags come only from registered occupancy, so no handshake input reaches them.
  assign full         = (occupancy == OCC_MAX);
  assign empty        = (occupancy == '0);
  assign below_thresh = (occupancy < OCC_THRESH);

  // Handshake decode. Flush masks both sides, and the read enable tracks non-empty.
  always_comb begin
    push_ready   = ~full & ~flush;
    pop_valid    = ~empty & ~flush;
    push_fire    = push_valid & push_ready;
    pop_fire     = pop_valid & pop_ready;
    fifo_wenable = push_fire;
    fifo_renable = ~empty;
  end

  // Next occupancy. A simultaneous push and pop cancel, and flush clears the count.
  always_comb begin
    occ_next = occupancy;
    if (flush) begin
      occ_next = '0;
    end else begin
      case ({push_fire, pop_fire})
        2'b10:   occ_next = occupancy + OCC_ONE;
        2'b01:   occ_next = occupancy - OCC_ONE;
        default: occ_next = occupancy;
      endcase
    end
  end

  // Next-state logic for the EMPTY / PARTIAL / FULL occupancy classes.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY:   if (push_fire) state_next = ST_PARTIAL;
        ST_PARTIAL: begin
          if (push_fire && !pop_fire && occupancy == OCC_LAST)
            state_next = ST_FULL;
          else if (pop_fire && !push_fire && occupancy == OCC_ONE)
            state_next = ST_EMPTY;
        end
        ST_FULL:    if (pop_fire) state_next = ST_PARTIAL;
        default:    state_next = ST_EMPTY;
      endcase
    end
  end

  // State register. It is kept in step with the occupancy counter.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) state <= ST_EMPTY;
    else           state <= state_next;
  end

  // Pointer and occupancy registers. Flush returns everything to the origin.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      occupancy <= '0;
    end else if (flush) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      occupancy <= '0;
    end else begin
      if (push_fire) write_ptr <= ptr_inc(write_ptr);
      if (pop_fire)  read_ptr  <= ptr_inc(read_ptr);
      occupancy <= occ_next;
    end
  end

`ifdef FIFO_CTRL_WATERMARK_EN
  // Peak occupancy plus a sticky push-while-full error. Both clear on flush.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      high_water   <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      high_water   <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (occ_next > high_water) high_water <= occ_next;
      if (push_valid && full)    overflow_err <= 1'b1;
    end
  end
`endif

  a_occ_bound: assert property (@(posedge clk_in) disable iff (!areset_b)
    occupancy <= OCC_MAX);
  a_no_write_full: assert property (@(posedge clk_in) disable iff (!areset_b)
    !(fifo_wenable && full));
  a_no_pop_empty: assert property (@(posedge clk_in) disable iff (!areset_b)
    !(pop_fire && empty));
  a_state_match: assert property (@(posedge clk_in) disable iff (!areset_b)
    ((state == ST_EMPTY) == empty) && ((state == ST_FULL) == full));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl with depth 8.
// A small behavioural array sits on the pointers, so data order is visible.
// Define FIFO_CTRL_WATERMARK_EN to also exercise high_water and overflow_err.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int CW    = 4;

  logic          clk_in = 1'b0;
  logic          areset_b = 1'b0;
  logic          push_valid = 1'b0;
  logic          pop_ready = 1'b0;
  logic          flush = 1'b0;
  logic          push_ready;
  logic          pop_valid;
  logic          fifo_wenable;
  logic          fifo_renable;
  logic [PW-1:0] write_ptr;
  logic [PW-1:0] read_ptr;
  logic [CW-1:0] occupancy;
  logic          full;
  logic          empty;
  logic          below_thresh;
`ifdef FIFO_CTRL_WATERMARK_EN
  logic [CW-1:0] high_water;
  logic          overflow_err;
`endif

  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [7:0] array_mem [DEPTH];

  int assert_count = 0;
  int fail_count   = 0;

  fifo_ctrl #(.OSTD_NUM(DEPTH)) dut (
    .clk_in       (clk_in),
    .areset_b     (areset_b),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .flush        (flush),
    .fifo_wenable (fifo_wenable),
    .fifo_renable (fifo_renable),
    .write_ptr    (write_ptr),
    .read_ptr     (read_ptr),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .below_thresh (below_thresh)
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    .high_water   (high_water),
    .overflow_err (overflow_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Behavioural storage array driven by the controller's enable and pointers.
  always @(posedge clk_in) if (fifo_wenable) array_mem[write_ptr] <= data_in;
  assign data_out = array_mem[read_ptr];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assert_count++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic pr, input logic fl,
                               input logic [7:0] din);
    push_valid = pv;
    pop_ready  = pr;
    flush      = fl;
    data_in    = din;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_occ"},   32'(occupancy), 0);
    checkOutput({tag, "_wptr"},  32'(write_ptr), 0);
    checkOutput({tag, "_rptr"},  32'(read_ptr), 0);
    checkOutput({tag, "_empty"}, 32'(empty), 1);
    checkOutput({tag, "_full"},  32'(full), 0);
    checkOutput({tag, "_prdy"},  32'(push_ready), 1);
    checkOutput({tag, "_pval"},  32'(pop_valid), 0);
    checkOutput({tag, "_wen"},   32'(fifo_wenable), 0);
    checkOutput({tag, "_ren"},   32'(fifo_renable), 0);
    checkOutput({tag, "_below"}, 32'(below_thresh), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset hold
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkResetState("reset");
`ifdef FIFO_CTRL_WATERMARK_EN
    checkOutput("reset_hw",  32'(high_water), 0);
    checkOutput("reset_ovf", 32'(overflow_err), 0);
`endif
    areset_b = 1'b1;
    tick();

    // Fill: eight pushes, no pops
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
      checkOutput("fill_wen",  32'(fifo_wenable), 1);
      checkOutput("fill_wptr", 32'(write_ptr), i);
      tick();
      checkOutput("fill_occ",   32'(occupancy), i + 1);
      checkOutput("fill_below", 32'(below_thresh), (i + 1 < 4) ? 1 : 0);
      checkOutput("fill_full",  32'(full), (i == DEPTH - 1) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("full_wptr_wrap", 32'(write_ptr), 0);
    checkOutput("full_prdy",      32'(push_ready), 0);
    checkOutput("full_pval",      32'(pop_valid), 1);
    checkOutput("full_ren",       32'(fifo_renable), 1);

    // Drain: eight pops, in write order
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("drain_rptr", 32'(read_ptr), i);
      checkOutput("drain_pval", 32'(pop_valid), 1);
      checkOutput("drain_data", 32'(data_out), 32'(8'hA0 + i));
      tick();
      checkOutput("drain_empty", 32'(empty), (i == DEPTH - 1) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("drain_rptr_wrap", 32'(read_ptr), 0);
    checkOutput("drain_occ",       32'(occupancy), 0);
    checkOutput("drain_pval_end",  32'(pop_valid), 0);

    // Empty boundary: push and pop together, so only the push is accepted
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    checkOutput("eb_pval", 32'(pop_valid), 0);
    checkOutput("eb_wen",  32'(fifo_wenable), 1);
    tick();
    checkOutput("eb_occ",  32'(occupancy), 1);
    checkOutput("eb_wptr", 32'(write_ptr), 1);
    checkOutput("eb_rptr", 32'(read_ptr), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("eb_data", 32'(data_out), 32'h55);
    checkOutput("eb_pval_next", 32'(pop_valid), 1);

    // Grow to occupancy 3
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
      tick();
    end
    checkOutput("grow_occ", 32'(occupancy), 3);

    // Simultaneous push and pop for ten cycles: head order 55, B0, B1, C0...
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'hC0 + k));
      checkOutput("sim_wen", 32'(fifo_wenable), 1);
      checkOutput("sim_data", 32'(data_out),
                  (k == 0) ? 32'h55 : (k == 1) ? 32'hB0 : (k == 2) ? 32'hB1 : 32'(8'hC0 + k - 3));
      tick();
      checkOutput("sim_occ", 32'(occupancy), 3);
    end
    checkOutput("sim_wptr", 32'(write_ptr), 5);
    checkOutput("sim_rptr", 32'(read_ptr), 2);

    // Top up to full
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hD0 + i));
      tick();
    end
    checkOutput("topup_occ",  32'(occupancy), 8);
    checkOutput("topup_full", 32'(full), 1);
    checkOutput("topup_wptr", 32'(write_ptr), 2);

    // Full boundary: push and pop together, so only the pop is accepted
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
    checkOutput("fb_prdy", 32'(push_ready), 0);
    checkOutput("fb_wen",  32'(fifo_wenable), 0);
    checkOutput("fb_pval", 32'(pop_valid), 1);
    tick();
    checkOutput("fb_occ",  32'(occupancy), 7);
    checkOutput("fb_rptr", 32'(read_ptr), 3);
    checkOutput("fb_wptr", 32'(write_ptr), 2);
    checkOutput("fb_full", 32'(full), 0);
`ifdef FIFO_CTRL_WATERMARK_EN
    checkOutput("fb_ovf", 32'(overflow_err), 1);
    checkOutput("fb_hw",  32'(high_water), 8);
`endif

    // Plain flush
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("fl_pval", 32'(pop_valid), 0);
    checkOutput("fl_prdy", 32'(push_ready), 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("fl_occ",   32'(occupancy), 0);
    checkOutput("fl_wptr",  32'(write_ptr), 0);
    checkOutput("fl_rptr",  32'(read_ptr), 0);
    checkOutput("fl_empty", 32'(empty), 1);
`ifdef FIFO_CTRL_WATERMARK_EN
    checkOutput("fl_hw",  32'(high_water), 0);
    checkOutput("fl_ovf", 32'(overflow_err), 0);
`endif

    // Five pushes, then flush while push_valid is still high
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      tick();
    end
    checkOutput("pf_occ", 32'(occupancy), 5);
`ifdef FIFO_CTRL_WATERMARK_EN
    checkOutput("pf_hw_before", 32'(high_water), 5);
`endif
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
    checkOutput("pf_wen", 32'(fifo_wenable), 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("pf_occ_after", 32'(occupancy), 0);
    checkOutput("pf_wptr",      32'(write_ptr), 0);
    checkOutput("pf_rptr",      32'(read_ptr), 0);
`ifdef FIFO_CTRL_WATERMARK_EN
    checkOutput("pf_hw_after", 32'(high_water), 0);
`endif

    // Reset asserted mid-fill, between clock edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
      tick();
    end
    checkOutput("mr_occ_before", 32'(occupancy), 3);
    #2;
    areset_b = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkResetState("midreset");
`ifdef FIFO_CTRL_WATERMARK_EN
    checkOutput("midreset_hw", 32'(high_water), 0);
`endif
    tick();
    areset_b = 1'b1;
    tick();
    checkOutput("mr_occ_after", 32'(occupancy), 0);
    checkOutput("mr_empty",     32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
